// File: rtl/change_dispenser.sv
// Change dispenser: greedily plans a payout from per-denomination inventory,
// then releases coins one at a time to the hopper over a valid/ack handshake.
module change_dispenser #(
    parameter int INV_W      = 8,
    parameter int INIT_COUNT = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [7:0]       change_amount,
    output logic             change_ready,
    output logic             coin_valid,
    output logic [7:0]       coin_value,
    input  logic             coin_ack,
    input  logic             refill,
    input  logic [1:0]       refill_denom,
    input  logic [INV_W-1:0] refill_count,
    output logic             done,
    output logic             error,
    output logic [7:0]       paid_total
);
    // Common width for comparing an 8-bit quotient against an inventory count.
    localparam int CW = (INV_W > 8) ? INV_W : 8;

    typedef enum logic [2:0] {S_IDLE, S_PLAN, S_DISPENSE, S_DONE, S_ERROR} state_t;

    state_t           state_reg, state_next;
    logic [INV_W-1:0] inv_reg  [4];   // index 0..3 holds 10, 20, 50, 100
    logic [INV_W-1:0] plan_reg [4];
    logic [7:0]       rem_reg;
    logic [1:0]       step_reg;
    logic [7:0]       paid_reg;

    function automatic logic [7:0] denom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'd10;
            2'd1:    return 8'd20;
            2'd2:    return 8'd50;
            default: return 8'd100;
        endcase
    endfunction

    logic          accept;
    logic [1:0]    plan_idx;
    logic [7:0]    plan_denom;
    logic [7:0]    quot;
    logic [CW-1:0] quot_w, inv_w, take_w;
    logic [7:0]    rem_after;

    always_comb begin
        accept     = (state_reg == S_IDLE) && change_valid;
        plan_idx   = ~step_reg;   // steps 0..3 visit 100, 50, 20, 10
        plan_denom = denom(plan_idx);
        quot       = rem_reg / plan_denom;
        quot_w     = CW'(quot);
        inv_w      = CW'(inv_reg[plan_idx]);
        take_w     = (quot_w < inv_w) ? quot_w : inv_w;
        rem_after  = rem_reg - 8'(take_w * CW'(plan_denom));
    end

    logic             coin_take;
    logic [1:0]       coin_idx;
    logic             any_left;
    logic [INV_W-1:0] plan_dec [4];

    // The offered coin is always the largest denomination still planned.
    always_comb begin
        coin_take = (state_reg == S_DISPENSE) && coin_ack;
        coin_idx  = 2'd0;
        for (int i = 0; i < 4; i++)
            if (plan_reg[i] != '0) coin_idx = 2'(i);
        any_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            plan_dec[i] = plan_reg[i];
            if (coin_take && coin_idx == 2'(i)) plan_dec[i] = plan_reg[i] - INV_W'(1);
            if (plan_dec[i] != '0) any_left = 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        change_ready = 1'b0;
        coin_valid   = 1'b0;
        coin_value   = 8'd0;
        done         = 1'b0;
        error        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                change_ready = 1'b1;
                if (change_valid) begin
                    if (change_amount == 8'd0)                 state_next = S_DONE;
                    else if ((change_amount % 8'd10) != 8'd0)  state_next = S_ERROR;
                    else                                       state_next = S_PLAN;
                end
            end
            S_PLAN: begin
                if (step_reg == 2'd3) state_next = (rem_after != 8'd0) ? S_ERROR : S_DISPENSE;
            end
            S_DISPENSE: begin
                coin_valid = 1'b1;
                coin_value = denom(coin_idx);
                if (coin_take && !any_left) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERROR: begin
                error      = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    logic [INV_W:0] refill_sum;
    assign refill_sum = {1'b0, inv_reg[refill_denom]} + {1'b0, refill_count};
    assign paid_total = paid_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                inv_reg[i]  <= INV_W'(INIT_COUNT);
                plan_reg[i] <= '0;
            end
            rem_reg  <= 8'd0;
            step_reg <= 2'd0;
            paid_reg <= 8'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (refill)
                        inv_reg[refill_denom] <= refill_sum[INV_W] ? '1 : refill_sum[INV_W-1:0];
                    if (accept) begin
                        rem_reg  <= change_amount;
                        paid_reg <= 8'd0;
                        step_reg <= 2'd0;
                        for (int i = 0; i < 4; i++) plan_reg[i] <= '0;
                    end
                end
                S_PLAN: begin
                    plan_reg[plan_idx] <= INV_W'(take_w);
                    rem_reg            <= rem_after;
                    step_reg           <= step_reg + 2'd1;
                end
                S_DISPENSE: begin
                    if (coin_take) begin
                        for (int i = 0; i < 4; i++) plan_reg[i] <= plan_dec[i];
                        inv_reg[coin_idx] <= inv_reg[coin_idx] - INV_W'(1);
                        paid_reg          <= paid_reg + denom(coin_idx);
                    end
                end
                S_ERROR: begin
                    paid_reg <= 8'd0;
                    for (int i = 0; i < 4; i++) plan_reg[i] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model predicts coin
// sequences, done/error pulses, paid totals and latencies for each request.
`timescale 1ns/1ps
module tb_change_dispenser;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = 8'd0;
    logic       change_ready;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       coin_ack = 1'b0;
    logic       refill = 1'b0;
    logic [1:0] refill_denom = 2'd0;
    logic [7:0] refill_count = 8'd0;
    logic       done;
    logic       error;
    logic [7:0] paid_total;

    change_dispenser #(.INV_W(8), .INIT_COUNT(10)) dut (
        .clock(clock), .reset(reset),
        .change_valid(change_valid), .change_amount(change_amount), .change_ready(change_ready),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ack(coin_ack),
        .refill(refill), .refill_denom(refill_denom), .refill_count(refill_count),
        .done(done), .error(error), .paid_total(paid_total)
    );

    always #5 clock = ~clock;

    typedef struct { int kind; int value; int lat; } exp_t;
    localparam int K_COIN = 0, K_DONE = 1, K_ERR = 2;

    exp_t sb[$];
    int   n_checks = 0, n_pass = 0;
    int   minv[4];                      // model inventory: 10, 20, 50, 100
    int   dval[4] = '{10, 20, 50, 100};
    int   cyc = 0, accept_cyc = 0, coins_seen = 0;
    int   ack_mode = 0, req_id = 0, rise_req = 0, rise_lat = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input int kind, input int value, input int lat);
        exp_t e;
        e.kind = kind; e.value = value; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic expect_out(input int kind, input int value);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_output_kind", kind, -1);
            return;
        end
        e = sb.pop_front();
        check("output_kind", kind, e.kind);
        if (kind == K_COIN) check("coin_value", value, e.value);
        else                check("paid_total", value, e.value);
        if (e.lat > 0) check("end_latency", cyc - accept_cyc + 1, e.lat);
    endtask

    task automatic model_refill(input int d, input int c);
        minv[d] = (minv[d] + c > 255) ? 255 : minv[d] + c;
    endtask

    // Greedy plan 100,50,20,10 bounded by inventory; all or nothing.
    task automatic model_request(input int amount, output bit pays);
        int rem;
        int n[4];
        pays = 1'b0;
        if (amount == 0) begin push_exp(K_DONE, 0, 1); return; end
        if (amount % 10 != 0) begin push_exp(K_ERR, 0, 1); return; end
        rem = amount;
        for (int i = 3; i >= 0; i--) begin
            n[i] = (rem / dval[i] < minv[i]) ? rem / dval[i] : minv[i];
            rem -= n[i] * dval[i];
        end
        if (rem != 0) begin push_exp(K_ERR, 0, 5); return; end
        for (int i = 3; i >= 0; i--) begin
            for (int k = 0; k < n[i]; k++) push_exp(K_COIN, dval[i], 0);
            minv[i] -= n[i];
        end
        push_exp(K_DONE, amount, 0);
        pays = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(posedge clock); #1; k++;
        end while (!change_ready && k < 300);
        if (!change_ready) check("idle_timeout", 0, 1);
    endtask

    task automatic do_refill(input int d, input int c);
        wait_idle();
        model_refill(d, c);
        refill = 1'b1; refill_denom = 2'(d); refill_count = 8'(c);
        @(posedge clock); #1;
        refill = 1'b0;
    endtask

    task automatic do_request(input int amount, input bit with_refill, input int rdenom,
                              input int rcount, input bit late_refill);
        bit pays;
        wait_idle();
        if (with_refill) model_refill(rdenom, rcount);
        model_request(amount, pays);
        if (pays) begin req_id++; rise_lat = 5; rise_req = req_id; end
        change_valid = 1'b1; change_amount = 8'(amount);
        refill = with_refill; refill_denom = 2'(rdenom); refill_count = 8'(rcount);
        @(posedge clock); #1;
        accept_cyc = cyc;
        change_valid = 1'b0; refill = 1'b0;
        if (late_refill) begin
            // Refill pulsed while coins are being dispensed must not reach inventory.
            int k = 0;
            while (!coin_valid && k < 20) begin @(posedge clock); #1; k++; end
            refill = 1'b1; refill_denom = 2'd1; refill_count = 8'd50;
            @(posedge clock); #1;
            refill = 1'b0;
        end
        wait_idle();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin : ack_driver
        int stall;
        stall = 0;
        forever begin
            @(posedge clock); #1;
            case (ack_mode)
                0: coin_ack = 1'b1;
                1: begin
                    if (!coin_valid)     begin stall = 0; coin_ack = 1'b0; end
                    else if (stall == 3) begin stall = 0; coin_ack = 1'b1; end
                    else                 begin stall++;   coin_ack = 1'b0; end
                end
                default: coin_ack = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    initial begin : monitor
        logic       prev_valid, prev_ack;
        logic [7:0] prev_value;
        int         seen_rise;
        prev_valid = 1'b0; prev_ack = 1'b0; prev_value = 8'd0; seen_rise = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_valid = 1'b0; prev_ack = 1'b0;
            end else begin
                if (coin_valid && !prev_valid && rise_req != seen_rise) begin
                    check("first_coin_latency", cyc - accept_cyc + 1, rise_lat);
                    seen_rise = rise_req;
                end
                if (coin_valid && prev_valid && !prev_ack)
                    check("coin_held_stable", int'(coin_value), int'(prev_value));
                if (coin_valid && coin_ack) begin
                    coins_seen++;
                    expect_out(K_COIN, int'(coin_value));
                end
                if (done || error) begin
                    check("end_coin_valid", int'(coin_valid), 0);
                    check("end_coin_value", int'(coin_value), 0);
                    check("end_ready_low", int'(change_ready), 0);
                    expect_out(done ? K_DONE : K_ERR, int'(paid_total));
                end
                prev_valid = coin_valid; prev_ack = coin_ack; prev_value = coin_value;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit pays;
        int base, k;
        for (int i = 0; i < 4; i++) minv[i] = 10;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", int'(change_ready), 1);
        check("reset_coin_valid", int'(coin_valid), 0);
        check("reset_coin_value", int'(coin_value), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        check("reset_paid", int'(paid_total), 0);
        reset = 1'b0;

        ack_mode = 0; do_request(180, 0, 0, 0, 0);
        ack_mode = 1; do_request(60, 0, 0, 0, 0);
        ack_mode = 0; do_request(35, 0, 0, 0, 0);
        do_request(0, 0, 0, 0, 0);

        // Reset while the second coin of a 180 payout is on offer.
        ack_mode = 1;
        wait_idle();
        model_request(180, pays);
        req_id++; rise_lat = 5; rise_req = req_id;
        change_valid = 1'b1; change_amount = 8'd180;
        @(posedge clock); #1;
        accept_cyc = cyc; change_valid = 1'b0;
        base = coins_seen; k = 0;
        while (!(coins_seen == base + 1 && coin_valid) && k < 100) begin
            @(posedge clock); #1; k++;
        end
        check("second_coin_offered", int'(coin_value), 50);
        reset = 1'b1; #1;
        check("midreset_ready", int'(change_ready), 1);
        check("midreset_coin_valid", int'(coin_valid), 0);
        check("midreset_coin_value", int'(coin_value), 0);
        check("midreset_paid", int'(paid_total), 0);
        sb.delete();
        for (int i = 0; i < 4; i++) minv[i] = 10;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("ready_after_reset", int'(change_ready), 1);
        check("valid_after_reset", int'(coin_valid), 0);

        // Drain the 50s, then the 20s and 10s, ending in a greedy failure.
        ack_mode = 0;
        for (int i = 0; i < 10; i++) do_request(50, 0, 0, 0, 0);
        do_request(60, 0, 0, 0, 1);
        do_request(90, 0, 0, 0, 0);
        do_request(90, 0, 0, 0, 0);
        do_request(60, 0, 0, 0, 0);
        do_request(60, 0, 0, 0, 0);

        // Saturating refill of 100s, then enough 100s to expose any wrap.
        do_refill(3, 250);
        for (int i = 0; i < 6; i++) do_request(200, 0, 0, 0, 0);
        do_request(150, 1, 2, 1, 0);

        ack_mode = 2;
        for (int t = 0; t < 40; t++) begin
            int amt;
            bit wr;
            if ($urandom_range(0, 7) == 0) amt = int'($urandom_range(0, 255));
            else                           amt = int'($urandom_range(0, 25)) * 10;
            wr = ($urandom_range(0, 3) == 0);
            do_request(amt, wr, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 0);
        end

        repeat (5) @(posedge clock);
        #1;
        check("final_queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
